// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared encodings for the pipeline stall/flush controller: stall vectors and EX FSM states.

package pipe_stall_ctrl_pkg;

    localparam logic [5:0] StallNone = 6'b000000;
    localparam logic [5:0] StallId   = 6'b000111;
    localparam logic [5:0] StallEx   = 6'b001111;
    localparam logic [5:0] StallMem  = 6'b011111;

    typedef enum logic [1:0] {
        ExIdle = 2'd0,
        ExBusy = 2'd1,
        ExHeld = 2'd2
    } ex_state_e;

endpackage

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush controller: merges ID/EX/MEM stall requests, tracks multi-cycle EX ops
// with a watchdog, and issues branch flush/redirect plus a saturating stall-cycle counter.

module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int unsigned MAX_EX_CYCLES = 64,
    parameter int unsigned CNT_W         = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stallreq_id,
    input  logic              ex_start,
    input  logic              ex_done,
    input  logic              mem_req,
    input  logic              mem_ack,
    input  logic              branch_flag_i,
    input  logic [31:0]       branch_target_i,
    output logic [5:0]        stall,
    output logic              flush,
    output logic [31:0]       new_pc,
    output logic              ex_timeout,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int unsigned           ExCntW    = $clog2(MAX_EX_CYCLES);
    localparam logic [ExCntW-1:0]     ExCntLast = ExCntW'(MAX_EX_CYCLES - 1);

    ex_state_e          ex_state_q, ex_state_d;
    logic [ExCntW-1:0]  ex_cnt_q, ex_cnt_d;
    logic               ex_timeout_q, ex_timeout_d;
    logic [CNT_W-1:0]   stall_cnt_q;

    logic               mem_stall;
    logic               ex_stall;
    logic               timeout_now;
    logic [5:0]         stall_vec;

    always_comb begin
        mem_stall   = mem_req & ~mem_ack;
        timeout_now = (ex_state_q == ExBusy) && !ex_done && (ex_cnt_q == ExCntLast);
        ex_stall    = ((ex_state_q == ExIdle) && ex_start && !ex_done) ||
                      ((ex_state_q == ExBusy) && !ex_done && !timeout_now);

        if (mem_stall) begin
            stall_vec = StallMem;
        end else if (ex_stall) begin
            stall_vec = StallEx;
        end else if (stallreq_id) begin
            stall_vec = StallId;
        end else begin
            stall_vec = StallNone;
        end
    end

    // Outputs are forced quiet while reset is held, independent of inputs.
    always_comb begin
        stall  = rst ? stall_vec : StallNone;
        flush  = rst && branch_flag_i && !stall_vec[2];
        new_pc = flush ? branch_target_i : 32'h0;
    end

    always_comb begin
        ex_state_d   = ex_state_q;
        ex_cnt_d     = ex_cnt_q;
        ex_timeout_d = ex_timeout_q;

        case (ex_state_q)
            ExIdle: begin
                // A done pulse without a start (or with it: zero-wait op) leaves us idle.
                if (ex_start && !ex_done) begin
                    ex_state_d = ExBusy;
                    ex_cnt_d   = '0;
                end
            end
            ExBusy: begin
                if (ex_done) begin
                    ex_state_d = mem_stall ? ExHeld : ExIdle;
                end else if (timeout_now) begin
                    ex_state_d   = ExIdle;
                    ex_timeout_d = 1'b1;
                end else begin
                    ex_cnt_d = ex_cnt_q + ExCntW'(1);
                end
            end
            ExHeld: begin
                if (!mem_stall) begin
                    ex_state_d = ExIdle;
                end
            end
            default: begin
                ex_state_d = ExIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_state_q   <= ExIdle;
            ex_cnt_q     <= '0;
            ex_timeout_q <= 1'b0;
            stall_cnt_q  <= '0;
        end else begin
            ex_state_q   <= ex_state_d;
            ex_cnt_q     <= ex_cnt_d;
            ex_timeout_q <= ex_timeout_d;
            if (stall_vec[0] && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
        end
    end

    assign ex_timeout = ex_timeout_q;
    assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: behavioural model checked every cycle plus
// directed scenarios with literal expectations.

module tb_pipe_stall_ctrl;

    localparam int unsigned MaxEx  = 8;
    localparam int unsigned CntW   = 4;
    localparam int          CntMax = (1 << CntW) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              stallreq_id = 1'b0;
    logic              ex_start = 1'b0;
    logic              ex_done = 1'b0;
    logic              mem_req = 1'b0;
    logic              mem_ack = 1'b0;
    logic              branch_flag_i = 1'b0;
    logic [31:0]       branch_target_i = 32'h0;
    logic [5:0]        stall;
    logic              flush;
    logic [31:0]       new_pc;
    logic              ex_timeout;
    logic [CntW-1:0]   stall_cnt;

    int checks = 0;
    int errors = 0;

    pipe_stall_ctrl #(
        .MAX_EX_CYCLES(MaxEx),
        .CNT_W        (CntW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stallreq_id    (stallreq_id),
        .ex_start       (ex_start),
        .ex_done        (ex_done),
        .mem_req        (mem_req),
        .mem_ack        (mem_ack),
        .branch_flag_i  (branch_flag_i),
        .branch_target_i(branch_target_i),
        .stall          (stall),
        .flush          (flush),
        .new_pc         (new_pc),
        .ex_timeout     (ex_timeout),
        .stall_cnt      (stall_cnt)
    );

    always #10 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an op is "outstanding" for a number of cycles (age), a finished op may be
    // "parked" behind a memory stall, and a stalled cycle bumps a capped count.
    bit m_op;
    bit m_held;
    int m_age;
    bit m_to;
    int m_cnt;

    function automatic logic [5:0] model_stall();
        bit mem_st;
        bit ex_st;
        if (!rst) return 6'b000000;
        mem_st = mem_req && !mem_ack;
        ex_st  = (m_op && !ex_done && (m_age != int'(MaxEx) - 1)) ||
                 (!m_op && !m_held && ex_start && !ex_done);
        if (mem_st) return 6'b011111;
        if (ex_st) return 6'b001111;
        if (stallreq_id) return 6'b000111;
        return 6'b000000;
    endfunction

    function automatic logic model_flush();
        logic [5:0] s;
        s = model_stall();
        return rst && branch_flag_i && (s < 6'b000111);
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_op   <= 1'b0;
            m_held <= 1'b0;
            m_age  <= 0;
            m_to   <= 1'b0;
            m_cnt  <= 0;
        end else begin
            if (model_stall() != 6'b000000 && m_cnt < CntMax) m_cnt <= m_cnt + 1;
            if (m_op) begin
                if (ex_done) begin
                    m_op   <= 1'b0;
                    m_held <= mem_req && !mem_ack;
                end else if (m_age == int'(MaxEx) - 1) begin
                    m_op <= 1'b0;
                    m_to <= 1'b1;
                end else begin
                    m_age <= m_age + 1;
                end
            end else if (m_held) begin
                if (!(mem_req && !mem_ack)) m_held <= 1'b0;
            end else if (ex_start && !ex_done) begin
                m_op  <= 1'b1;
                m_age <= 0;
            end
        end
    end

    always @(negedge clk) begin
        logic ef;
        ef = model_flush();
        chk("m_stall", 32'(stall), 32'(model_stall()));
        chk("m_flush", 32'(flush), 32'(ef));
        chk("m_new_pc", new_pc, ef ? branch_target_i : 32'h0);
        chk("m_timeout", 32'(ex_timeout), 32'(m_to));
        chk("m_stall_cnt", 32'(stall_cnt), 32'(m_cnt));
    end

    // One pipeline cycle: drive inputs just after the edge, return mid-low-phase for checks.
    task automatic step(input logic sid, input logic es, input logic ed, input logic mr,
                        input logic ma, input logic bf, input logic [31:0] bt);
        @(posedge clk);
        #2;
        stallreq_id     = sid;
        ex_start        = es;
        ex_done         = ed;
        mem_req         = mr;
        mem_ack         = ma;
        branch_flag_i   = bf;
        branch_target_i = bt;
        #3;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        #3;
        chk("rst_stall", 32'(stall), 32'h0);
        chk("rst_cnt", 32'(stall_cnt), 32'h0);
        chk("rst_timeout", 32'(ex_timeout), 32'h0);

        // Load-use
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("lu_stall", 32'(stall), 32'h07);
        chk("lu_flush", 32'(flush), 32'h0);
        idle();
        chk("lu_after", 32'(stall), 32'h0);
        chk("lu_cnt", 32'(stall_cnt), 32'd1);

        // Divide: done five cycles after start
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("div_c0", 32'(stall), 32'h0f);
        for (int i = 1; i < 5; i++) begin
            idle();
            chk("div_busy", 32'(stall), 32'h0f);
        end
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("div_done", 32'(stall), 32'h0);
        idle();
        chk("div_c6", 32'(stall), 32'h0);
        chk("div_cnt", 32'(stall_cnt), 32'd6);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("stray_done", 32'(stall), 32'h0);
        idle();

        // Overlap with MEM stall
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        idle();
        idle();
        chk("ov_c2", 32'(stall), 32'h0f);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("ov_c3", 32'(stall), 32'h1f);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("ov_c4", 32'(stall), 32'h1f);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("ov_c6", 32'(stall), 32'h1f);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("ov_c7", 32'(stall), 32'h0);
        idle();
        chk("ov_cnt", 32'(stall_cnt), 32'd13);

        // Zero-wait op
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("zw_stall", 32'(stall), 32'h0);
        idle();
        chk("zw_after", 32'(stall), 32'h0);

        // Branches
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0100);
        chk("br_flush", 32'(flush), 32'h1);
        chk("br_pc", new_pc, 32'h100);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0100);
        chk("br_id_flush", 32'(flush), 32'h0);
        chk("br_id_pc", new_pc, 32'h0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0200);
        chk("br_ex_flush", 32'(flush), 32'h0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0300);
        chk("br_mem_flush", 32'(flush), 32'h0);
        chk("br_mem_stall", 32'(stall), 32'h1f);
        idle();
        chk("sat_cnt", 32'(stall_cnt), 32'd15);

        // Watchdog
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 1; i < 8; i++) begin
            idle();
            chk("wd_busy", 32'(stall), 32'h0f);
        end
        idle();
        chk("wd_release", 32'(stall), 32'h0);
        chk("wd_to_early", 32'(ex_timeout), 32'h0);
        idle();
        chk("wd_to", 32'(ex_timeout), 32'h1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("wd_to_held", 32'(ex_timeout), 32'h1);
        chk("wd_late_done", 32'(stall), 32'h0);

        // Async reset mid-op
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        idle();
        chk("rs_busy", 32'(stall), 32'h0f);
        #1;
        rst           = 1'b0;
        ex_start      = 1'b1;
        stallreq_id   = 1'b1;
        branch_flag_i = 1'b1;
        #1;
        chk("rs_stall", 32'(stall), 32'h0);
        chk("rs_flush", 32'(flush), 32'h0);
        chk("rs_cnt", 32'(stall_cnt), 32'h0);
        chk("rs_to", 32'(ex_timeout), 32'h0);
        @(posedge clk);
        #2;
        stallreq_id   = 1'b0;
        ex_start      = 1'b0;
        branch_flag_i = 1'b0;
        rst           = 1'b1;
        #3;
        chk("rs_abandon", 32'(stall), 32'h0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        idle();
        chk("rs_cnt_after", 32'(stall_cnt), 32'd1);

        @(posedge clk);
        #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_stall_ctrl.md
# pipe_stall_ctrl

Central stall/flush controller for the six-stage pipeline. It merges hazard and busy requests from ID, EX and MEM, and tracks multi-cycle EX operations and MEM handshakes. It drives the `stall[5:0]` vector consumed by the pc, if_id, id_ex, ex_mem and mem_wb registers, and issues the branch flush and redirect. A saturating stall-cycle counter and a sticky EX-timeout flag are provided for debug.

## Interface
Parameters:
- MAX_EX_CYCLES, 64: EX watchdog limit in cycles; must be ≥2.
- CNT_W, 32: width of the stall-cycle counter.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous, active-low reset.
- stallreq_id  in  1  load-use hazard from ID.
- ex_start  in  1  a multi-cycle op is in EX this cycle; single-cycle pulse.
- ex_done  in  1  multi-cycle op result valid; single-cycle pulse.
- mem_req  in  1  MEM stage has an outstanding memory access; level signal.
- mem_ack  in  1  memory access completes this cycle.
- branch_flag_i  in  1  taken branch/jump resolved in ID.
- branch_target_i  in  32  redirect address.
- stall  out  6  bit0 pc, bit1 if_id, bit2 id_ex, bit3 ex_mem, bit4 mem_wb, bit5 reserved (always 0).
- flush  out  1  squash if_id and redirect pc this cycle.
- new_pc  out  32  branch_target_i when flush=1, else 0.
- ex_timeout  out  1  sticky watchdog error.
- stall_cnt  out  CNT_W  number of cycles with stall[0]=1, saturating.

## Operation
- EX FSM states:
  - EX_IDLE.
  - EX_BUSY: the EX unit is computing.
  - EX_HELD: the result is ready but EX is frozen by a MEM stall.
- EX FSM transitions:
  - EX_IDLE: ex_start & !ex_done goes to EX_BUSY. ex_start & ex_done is a zero-wait op; stay in EX_IDLE with no EX stall.
  - EX_BUSY: ex_done & mem_stall goes to EX_HELD. ex_done & !mem_stall goes to EX_IDLE. If ex_cnt reaches MAX_EX_CYCLES-1 without ex_done, set ex_timeout and go to EX_IDLE.
  - EX_HELD: !mem_stall goes to EX_IDLE.
- ex_cnt clears on entry to EX_BUSY and increments each EX_BUSY cycle.
- Stall request signals:
  - mem_stall = mem_req & !mem_ack. MEM needs no separate state, because mem_req is held until ack.
  - ex_stall = (EX_IDLE & ex_start & !ex_done) | (EX_BUSY & !ex_done & !timeout_now).
- Stall vector, evaluated in priority order:
  - mem_stall gives 6'b011111.
  - Otherwise ex_stall gives 6'b001111.
  - Otherwise stallreq_id gives 6'b000111. This freezes pc, if_id and id_ex; id_ex inserts a bubble because stall[2]=1 and stall[3]=0.
  - Otherwise 6'b000000.
- In EX_HELD, EX never stalls on its own account; it is frozen only by mem_stall.
- Flush rules:
  - flush = branch_flag_i & !stall[2].
  - A branch during any ID/EX/MEM stall is ignored that cycle. ID re-presents the branch once the stall clears.
  - Flush and stallreq_id are mutually exclusive by this rule.
- Error and counter behaviour:
  - ex_timeout stays set until reset.
  - ex_done arriving in EX_IDLE without a preceding ex_start is ignored.
  - stall_cnt increments when stall[0]=1 and holds at all-ones.

## Timing
- stall, flush and new_pc are combinational from the current state and inputs, so they take effect at the same edge as the request.
- EX FSM, ex_cnt, ex_timeout and stall_cnt are registered.
- An op with ex_done N cycles after ex_start stalls N cycles. Stall drops in the ex_done cycle so EX/MEM captures the result at the following edge.
- A timeout releases the stall in the cycle ex_cnt=MAX_EX_CYCLES-1, and ex_timeout is visible the next cycle.
- Reset (asynchronous, active-low):
  - EX FSM goes to EX_IDLE; ex_cnt=0, ex_timeout=0, stall_cnt=0.
  - While rst=0, stall=0, flush=0 and new_pc=0, forced regardless of inputs.
  - Reset mid-EX_BUSY abandons the op.

## Structure
- Add stall encodings to the shared defines: StallNone 6'b000000, StallId 6'b000111, StallEx 6'b001111, StallMem 6'b011111.
- Add the EX FSM state encoding (2 bits) to the shared defines.
- Single module, no sub-modules. A saturating counter inline is sufficient.

## Test plan
- Load-use: stallreq_id=1 for 1 cycle with nothing else active → stall=6'b000111 for exactly that cycle, flush=0, stall_cnt=1.
- Divide: ex_start at cycle 0, ex_done at cycle 5 → stall=6'b001111 for cycles 0–4, 0 at cycle 5, FSM back to EX_IDLE at cycle 6.
- Overlap: in EX_BUSY, mem_req=1 cycles 3–7, ex_done at cycle 4, mem_ack at cycle 7 → stall=6'b011111 for cycles 3–6, EX_HELD for cycles 5–7, stall=0 at cycle 7.
- Branch: branch_flag_i=1 with target 0x0000_0100, no stall → flush=1, new_pc=0x100. Repeat with stallreq_id=1 → flush=0, new_pc=0.
- Watchdog: MAX_EX_CYCLES=8, ex_start with no ex_done → stall=6'b001111 for 8 cycles, then released, ex_timeout=1 held until rst.
- Reset: assert rst=0 asynchronously mid-EX_BUSY → stall=0 immediately, state EX_IDLE, stall_cnt=0, ex_timeout=0.
